// File: rtl/auto_player.sv
// Automated tic-tac-toe player: answers the game FSM's move request with a pseudo-random empty
// square after a think delay and keeps saturating result tallies. Option: AUTO_PLAYER_BADMOVE_EN.
module auto_player #(
    parameter int unsigned THINK_CYCLES = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [17:0] i_board,
    input  logic [1:0]  i_result,
    input  logic        i_isdraw,
    input  logic        i_result_stb,
    input  logic        i_need_userinput,
    output logic        o_user_busy,
    output logic [3:0]  o_user_move,
    output logic        o_usermove_stb,
    output logic [7:0]  o_xwins,
    output logic [7:0]  o_owins,
    output logic [7:0]  o_draws
);

    localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] THINK_LOAD = 16'(THINK_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StThink, StScan, StStrobe, StWaitDrop} state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_lfsr;
    logic [15:0] r_think_cnt;
    logic [3:0]  r_idx;
    logic [3:0]  r_scan_cnt;
    logic        r_busy;
    logic        r_stb;
    logic [3:0]  r_move;
    logic [7:0]  r_xwins, r_owins, r_draws;

    logic        w_busy_d;
    logic        w_stb_d;
    logic [3:0]  w_move_d;
    logic [1:0]  w_square;
    logic        w_square_empty;
    logic        w_last_scan;
    logic        w_bad;
    logic [3:0]  w_start_idx;
    logic [3:0]  w_next_idx;

`ifdef AUTO_PLAYER_BADMOVE_EN
    logic [2:0] r_move_cnt;
    logic       r_bad;
    assign w_bad = r_bad;
`else
    assign w_bad = 1'b0;
`endif

    always_comb begin
        w_square = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (r_idx == 4'(i)) w_square = i_board[2*i +: 2];
        end
    end

    assign w_square_empty = (w_square == 2'b00);
    assign w_last_scan    = (r_scan_cnt == 4'd8);
    assign w_start_idx    = (r_lfsr[3:0] >= 4'd9) ? r_lfsr[3:0] - 4'd9 : r_lfsr[3:0];
    assign w_next_idx     = (r_idx == 4'd8) ? 4'd0 : r_idx + 4'd1;

    // State register and datapath counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_lfsr      <= SEED;
            r_think_cnt <= '0;
            r_idx       <= '0;
            r_scan_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            unique case (r_state)
                StIdle: begin
                    if (i_need_userinput) r_think_cnt <= THINK_LOAD;
                end
                StThink: begin
                    if (r_think_cnt == 16'd0) begin
                        r_idx      <= w_start_idx;
                        r_scan_cnt <= '0;
                    end else begin
                        r_think_cnt <= r_think_cnt - 16'd1;
                    end
                end
                StScan: begin
                    r_idx      <= w_next_idx;
                    r_scan_cnt <= r_scan_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef AUTO_PLAYER_BADMOVE_EN
    // Every eighth move is forced invalid to exercise the game FSM's retry path
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_move_cnt <= '0;
            r_bad      <= 1'b0;
        end else begin
            if (w_stb_d) r_move_cnt <= r_move_cnt + 3'd1;
            if (r_state == StThink && r_think_cnt == 16'd0) r_bad <= (r_move_cnt == 3'd7);
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:     if (i_need_userinput) w_state_next = StThink;
            StThink:    if (r_think_cnt == 16'd0) w_state_next = StScan;
            StScan: begin
                if (w_bad || w_square_empty) w_state_next = StStrobe;
                else if (w_last_scan)        w_state_next = StIdle;
            end
            StStrobe:   w_state_next = StWaitDrop;
            StWaitDrop: if (!i_need_userinput) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_busy_d = r_busy;
        w_stb_d  = 1'b0;
        w_move_d = r_move;
        unique case (r_state)
            StIdle: if (i_need_userinput) w_busy_d = 1'b1;
            StScan: begin
                if (w_bad) begin
                    w_busy_d = 1'b0;
                    w_stb_d  = 1'b1;
                    w_move_d = 4'd0;
                end else if (w_square_empty) begin
                    w_busy_d = 1'b0;
                    w_stb_d  = 1'b1;
                    w_move_d = r_idx + 4'd1;
                end else if (w_last_scan) begin
                    w_busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy <= 1'b0;
            r_stb  <= 1'b0;
            r_move <= '0;
        end else begin
            r_busy <= w_busy_d;
            r_stb  <= w_stb_d;
            r_move <= w_move_d;
        end
    end

    // Draw has priority over the win checks, as in the game FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_xwins <= '0;
            r_owins <= '0;
            r_draws <= '0;
        end else if (i_result_stb) begin
            if (i_isdraw) begin
                if (r_draws != 8'hFF) r_draws <= r_draws + 8'd1;
            end else if (i_result == 2'd1) begin
                if (r_xwins != 8'hFF) r_xwins <= r_xwins + 8'd1;
            end else if (i_result == 2'd2) begin
                if (r_owins != 8'hFF) r_owins <= r_owins + 8'd1;
            end
        end
    end

    assign o_user_busy    = r_busy;
    assign o_usermove_stb = r_stb;
    assign o_user_move    = r_move;
    assign o_xwins        = r_xwins;
    assign o_owins        = r_owins;
    assign o_draws        = r_draws;

endmodule

// File: tb/tb_auto_player.sv
// Directed self-checking bench for auto_player (THINK_CYCLES=4); the invalid-move test runs only
// when AUTO_PLAYER_BADMOVE_EN is defined.
module tb_auto_player;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [17:0] i_board;
    logic [1:0]  i_result;
    logic        i_isdraw;
    logic        i_result_stb;
    logic        i_need;
    logic        o_busy;
    logic [3:0]  o_move;
    logic        o_stb;
    logic [7:0]  o_xwins, o_owins, o_draws;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    auto_player #(
        .THINK_CYCLES(4)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_board          (i_board),
        .i_result         (i_result),
        .i_isdraw         (i_isdraw),
        .i_result_stb     (i_result_stb),
        .i_need_userinput (i_need),
        .o_user_busy      (o_busy),
        .o_user_move      (o_move),
        .o_usermove_stb   (o_stb),
        .o_xwins          (o_xwins),
        .o_owins          (o_owins),
        .o_draws          (o_draws)
    );

    // Stimulus only: raise a request for one cycle and record the strobe it produces
    task automatic do_request(output int stb_cyc, output logic [3:0] mv, output int nstb,
                              output logic busy_at_stb);
        stb_cyc     = -1;
        mv          = 4'hF;
        nstb        = 0;
        busy_at_stb = 1'b1;
        @(negedge clk);
        i_need = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) i_need = 1'b0;
            if (o_stb) begin
                nstb++;
                if (stb_cyc < 0) begin
                    stb_cyc     = k;
                    mv          = o_move;
                    busy_at_stb = o_busy;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_need  = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic pulse_result(input logic draw, input logic [1:0] res);
        @(negedge clk);
        i_result_stb = 1'b1;
        i_isdraw     = draw;
        i_result     = res;
        @(negedge clk);
        i_result_stb = 1'b0;
        i_isdraw     = 1'b0;
        i_result     = 2'd0;
    endtask

    task automatic test_reset();
        i_reset      = 1'b1;
        i_board      = '0;
        i_result     = '0;
        i_isdraw     = 1'b0;
        i_result_stb = 1'b0;
        i_need       = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", o_stb); end
        checks++; if (o_move !== 4'd0) begin errors++; $display("FAIL reset_move got %0d want 0", o_move); end
        checks++;
        if ({o_xwins, o_owins, o_draws} !== 24'd0) begin
            errors++;
            $display("FAIL reset_tallies got %0d/%0d/%0d want 0/0/0", o_xwins, o_owins, o_draws);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_empty_board();
        logic exp_busy, exp_stb;
        apply_reset();
        i_board = '0;
        @(negedge clk);
        i_need = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_busy = (k <= 5);
            exp_stb  = (k == 6);
            checks++;
            if (o_busy !== exp_busy) begin
                errors++;
                $display("FAIL empty_busy cycle %0d got %b want %b", k, o_busy, exp_busy);
            end
            checks++;
            if (o_stb !== exp_stb) begin
                errors++;
                $display("FAIL empty_stb cycle %0d got %b want %b", k, o_stb, exp_stb);
            end
            if (k == 6) begin
                checks++;
                if (o_move < 4'd1 || o_move > 4'd9) begin
                    errors++;
                    $display("FAIL empty_move got %0d want 1..9", o_move);
                end
                i_need = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_one_empty();
        logic [17:0] boards [3];
        logic [3:0]  moves  [3];
        int          cyc, n;
        logic [3:0]  mv;
        logic        bz;
        apply_reset();
        boards[0] = 18'h3FFFC; moves[0] = 4'd1;
        boards[1] = 18'h0FFFF; moves[1] = 4'd9;
        boards[2] = 18'h3FF3F; moves[2] = 4'd4;
        for (int b = 0; b < 3; b++) begin
            i_board = boards[b];
            for (int r = 0; r < 2; r++) begin
                do_request(cyc, mv, n, bz);
                checks++;
                if (n !== 1) begin errors++; $display("FAIL one_empty_nstb board %0d got %0d want 1", b, n); end
                checks++;
                if (mv !== moves[b]) begin
                    errors++;
                    $display("FAIL one_empty_move board %0d got %0d want %0d", b, mv, moves[b]);
                end
                checks++;
                if (cyc < 6 || cyc > 15) begin
                    errors++;
                    $display("FAIL one_empty_cycle board %0d got %0d want 6..15", b, cyc);
                end
                checks++;
                if (bz !== 1'b0) begin errors++; $display("FAIL one_empty_busy_at_stb got %b want 0", bz); end
            end
        end
    endtask

    task automatic test_full_board();
        int         cyc, n;
        logic [3:0] mv;
        logic       bz;
        logic       exp_busy;
        apply_reset();
        i_board = 18'h3FFFF;
        @(negedge clk);
        i_need = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) i_need = 1'b0;
            exp_busy = (k <= 13);
            checks++;
            if (o_busy !== exp_busy) begin
                errors++;
                $display("FAIL full_busy cycle %0d got %b want %b", k, o_busy, exp_busy);
            end
            checks++;
            if (o_stb !== 1'b0) begin errors++; $display("FAIL full_stb cycle %0d got %b want 0", k, o_stb); end
        end
        // Back in IDLE: a fresh request on an empty board runs at nominal latency
        i_board = '0;
        do_request(cyc, mv, n, bz);
        checks++;
        if (cyc !== 6 || n !== 1) begin
            errors++;
            $display("FAIL full_then_idle got cycle %0d count %0d want cycle 6 count 1", cyc, n);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        apply_reset();
        i_board = '0;
        @(negedge clk);
        i_need = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_stb) n++;
            if (k > 6) begin
                checks++;
                if (o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL held_busy cycle %0d got %b want 0", k, o_busy);
                end
            end
        end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL held_nstb got %0d want 1", n); end
        i_need = 1'b0;
        @(negedge clk);
        i_need = 1'b1;
        @(negedge clk);
        i_need = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL rerequest_busy got %b want 1", o_busy); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_tallies();
        apply_reset();
        pulse_result(1'b1, 2'd1);
        checks++;
        if (o_draws !== 8'd1 || o_xwins !== 8'd0) begin
            errors++;
            $display("FAIL draw_priority got draws %0d xwins %0d want 1 0", o_draws, o_xwins);
        end
        pulse_result(1'b0, 2'd1);
        checks++;
        if (o_xwins !== 8'd1) begin errors++; $display("FAIL xwin got %0d want 1", o_xwins); end
        pulse_result(1'b0, 2'd0);
        checks++;
        if ({o_xwins, o_owins, o_draws} !== {8'd1, 8'd0, 8'd1}) begin
            errors++;
            $display("FAIL none_result got %0d/%0d/%0d want 1/0/1", o_xwins, o_owins, o_draws);
        end
        pulse_result(1'b1, 2'd2);
        checks++;
        if (o_draws !== 8'd2 || o_owins !== 8'd0) begin
            errors++;
            $display("FAIL draw_over_owin got draws %0d owins %0d want 2 0", o_draws, o_owins);
        end
        repeat (254) pulse_result(1'b0, 2'd2);
        checks++;
        if (o_owins !== 8'd254) begin errors++; $display("FAIL owins_254 got %0d want 254", o_owins); end
        repeat (46) pulse_result(1'b0, 2'd2);
        checks++;
        if (o_owins !== 8'd255) begin errors++; $display("FAIL owins_sat got %0d want 255", o_owins); end
    endtask

    task automatic test_reset_mid_scan();
        int n = 0;
        i_board = 18'h0FFFF;
        @(negedge clk);
        i_need = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL midscan_busy got %b want 1", o_busy); end
        i_reset = 1'b1;
        i_need  = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_busy, o_stb, o_move} !== 6'd0) begin
            errors++;
            $display("FAIL midscan_reset_outputs got busy %b stb %b move %0d want 0 0 0",
                     o_busy, o_stb, o_move);
        end
        checks++;
        if ({o_xwins, o_owins, o_draws} !== 24'd0) begin
            errors++;
            $display("FAIL midscan_reset_tallies got %0d/%0d/%0d want 0/0/0", o_xwins, o_owins, o_draws);
        end
        i_reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (o_stb) n++;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL midscan_no_strobe got %0d want 0", n); end
    endtask

`ifdef AUTO_PLAYER_BADMOVE_EN
    task automatic test_badmove();
        int         cyc, n;
        logic [3:0] mv;
        logic       bz;
        apply_reset();
        i_board = '0;
        for (int r = 1; r <= 8; r++) begin
            do_request(cyc, mv, n, bz);
            checks++;
            if (n !== 1) begin errors++; $display("FAIL bad_nstb request %0d got %0d want 1", r, n); end
            if (r < 8) begin
                checks++;
                if (mv < 4'd1 || mv > 4'd9) begin
                    errors++;
                    $display("FAIL bad_valid_move request %0d got %0d want 1..9", r, mv);
                end
            end else begin
                checks++;
                if (mv !== 4'd0 || cyc !== 6) begin
                    errors++;
                    $display("FAIL bad_eighth got move %0d cycle %0d want 0 6", mv, cyc);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_PLAYER_BADMOVE_EN
        test_badmove();
`endif
        test_empty_board();
        test_one_empty();
        test_full_board();
        test_back_to_back();
        test_tallies();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
